// File: rtl/sram_stream_writer.sv
// Write-side master for the SRAM controller user port.
// Takes a valid/ready word stream and writes it to consecutive addresses
// starting at a programmable base. The address wraps at 2^ADDR_WIDTH.
// An optional idle gap can be forced after each write.
module sram_stream_writer #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 18,
  parameter int WRITE_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write_enable,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_written
);

  localparam int GAP_W = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   remain_q;
  logic [ADDR_WIDTH-1:0]   words_q;
  logic [GAP_W-1:0]        gap_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_p1;
  logic [DATA_WIDTH-1:0]   mem_data_p1;
  logic                    vld_p1;
  logic                    accept;

  // Address advance; all-ones rolls over to zero.
  function automatic logic [ADDR_WIDTH-1:0] addr_wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  // Gap countdown that stops at zero.
  function automatic logic [GAP_W-1:0] gap_sat_dec(input logic [GAP_W-1:0] g);
    return (g == '0) ? g : g - GAP_W'(1);
  endfunction

  // Stage p0: stream handshake; abort blocks acceptance in the same cycle.
  assign in_ready = (state_q == WRITE) && (gap_q == '0) && !abort;
  assign accept   = in_valid && in_ready;

  // Stage p0 -> p1: control FSM and registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      words_q     <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_p1 <= '0;
      mem_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            words_q <= '0;
            if (word_count != '0) begin
              addr_q   <= base_addr;
              remain_q <= word_count;
              gap_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= WRITE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            gap_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (accept) begin
            vld_p1      <= 1'b1;
            mem_addr_p1 <= addr_q;
            mem_data_p1 <= in_data;
            addr_q      <= addr_wrap_inc(addr_q);
            remain_q    <= remain_q - ADDR_WIDTH'(1);
            words_q     <= words_q + ADDR_WIDTH'(1);
            gap_q       <= GAP_LOAD;
            if (remain_q == ADDR_WIDTH'(1)) begin
              state_q <= FLUSH;
            end
          end else begin
            gap_q <= gap_sat_dec(gap_q);
          end
        end
        FLUSH: begin
          gap_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: outputs to the SRAM controller.
  assign mem_addr         = mem_addr_p1;
  assign mem_data         = mem_data_p1;
  assign mem_write_enable = vld_p1;
  assign busy             = busy_q;
  assign done             = done_q;
  assign words_written    = words_q;

endmodule

// File: tb/tb_sram_stream_writer.sv
// Directed bench for sram_stream_writer: one instance with no write gap,
// one with a two-cycle gap, both driven from the same stimulus.
module tb_sram_stream_writer;

  localparam int AW = 20;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;

  logic          rdy0, we0, busy0, done0;
  logic [AW-1:0] addr0, words0;
  logic [DW-1:0] data0;
  logic          rdy2, we2, busy2, done2;
  logic [AW-1:0] addr2, words2;
  logic [DW-1:0] data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_addr(addr0), .mem_data(data0), .mem_write_enable(we0),
    .busy(busy0), .done(done0), .words_written(words0)
  );

  sram_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_GAP(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy2), .mem_addr(addr2), .mem_data(data2), .mem_write_enable(we2),
    .busy(busy2), .done(done2), .words_written(words2)
  );

  typedef struct {
    logic          s;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic          ab;
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] md;
    logic          bsy;
    logic          dn;
    logic [AW-1:0] w;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic s, input logic [AW-1:0] b, input logic [AW-1:0] c,
                              input logic ab, input logic v, input logic [DW-1:0] d,
                              input logic rdy, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] md, input logic bsy, input logic dn,
                              input logic [AW-1:0] w);
    vec_t r;
    r.s = s; r.b = b; r.c = c; r.ab = ab; r.v = v; r.d = d;
    r.rdy = rdy; r.we = we; r.a = a; r.md = md; r.bsy = bsy; r.dn = dn; r.w = w;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [AW-1:0] b, input logic [AW-1:0] c,
                       input logic ab, input logic v, input logic [DW-1:0] d);
    start      = s;
    base_addr  = b;
    word_count = c;
    abort      = ab;
    in_valid   = v;
    in_data    = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic          exp_we;
    logic          prev_we;
    logic [AW-1:0] exp_a;

    // Basic 4-word run, then start+abort during FLUSH, then zero length.
    tbl[0] = mk(1'b1, 20'h00010, 20'd4, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 20'h0, 18'h0, 1'b1, 1'b0, 20'd0);
    tbl[1] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b1, 18'h1, 1'b1, 1'b1, 20'h00010, 18'h1, 1'b1, 1'b0, 20'd1);
    tbl[2] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b1, 18'h2, 1'b1, 1'b1, 20'h00011, 18'h2, 1'b1, 1'b0, 20'd2);
    tbl[3] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b1, 18'h3, 1'b1, 1'b1, 20'h00012, 18'h3, 1'b1, 1'b0, 20'd3);
    tbl[4] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b1, 18'h4, 1'b1, 1'b1, 20'h00013, 18'h4, 1'b1, 1'b0, 20'd4);
    tbl[5] = mk(1'b1, 20'h00777, 20'd2, 1'b1, 1'b1, 18'h5, 1'b0, 1'b0, 20'h00013, 18'h4, 1'b0, 1'b1, 20'd4);
    tbl[6] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 20'h00013, 18'h4, 1'b0, 1'b0, 20'd4);
    tbl[7] = mk(1'b1, 20'h00055, 20'd0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 20'h00013, 18'h4, 1'b0, 1'b1, 20'd0);
    tbl[8] = mk(1'b0, 20'h0, 20'd0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 20'h00013, 18'h4, 1'b0, 1'b0, 20'd0);

    // Reset state.
    reset = 1'b0;
    tick();
    tick();
    chk1("rst_rdy", rdy0, 1'b0);
    chk1("rst_we", we0, 1'b0);
    chka("rst_addr", addr0, '0);
    chkd("rst_data", data0, '0);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_done", done0, 1'b0);
    chka("rst_words", words0, '0);
    chk1("rst_busy_g2", busy2, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].s, tbl[i].b, tbl[i].c, tbl[i].ab, tbl[i].v, tbl[i].d);
      #2;
      chk1($sformatf("tbl%0d_rdy", i), rdy0, tbl[i].rdy);
      tick();
      chk1($sformatf("tbl%0d_we", i), we0, tbl[i].we);
      chka($sformatf("tbl%0d_addr", i), addr0, tbl[i].a);
      chkd($sformatf("tbl%0d_data", i), data0, tbl[i].md);
      chk1($sformatf("tbl%0d_busy", i), busy0, tbl[i].bsy);
      chk1($sformatf("tbl%0d_done", i), done0, tbl[i].dn);
      chka($sformatf("tbl%0d_words", i), words0, tbl[i].w);
    end

    // Gap of 2 cycles: writes at k=1,4,7; done at k=8.
    do_reset();
    drive(1'b1, 20'h00100, 20'd3, 1'b0, 1'b0, '0);
    #2;
    chk1("gap_rdy_start", rdy2, 1'b0);
    tick();
    prev_we = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, DW'(32'h20 + k));
      exp_we = (k <= 7) && (k % 3 == 1);
      #2;
      chk1($sformatf("gap_rdy_k%0d", k), rdy2, exp_we);
      tick();
      chk1($sformatf("gap_we_k%0d", k), we2, exp_we);
      if (exp_we) begin
        chka($sformatf("gap_addr_k%0d", k), addr2, AW'(32'h100 + (k - 1) / 3));
        chkd($sformatf("gap_data_k%0d", k), data2, DW'(32'h20 + k));
      end
      if (prev_we) chk1($sformatf("gap_b2b_k%0d", k), we2, 1'b0);
      prev_we = we2;
      chk1($sformatf("gap_done_k%0d", k), done2, (k == 8));
      chk1($sformatf("gap_busy_k%0d", k), busy2, (k <= 7));
    end
    chka("gap_words", words2, 20'd3);

    // Address wrap.
    do_reset();
    drive(1'b1, 20'hFFFFE, 20'd4, 1'b0, 1'b0, '0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, DW'(k));
      tick();
      exp_a = AW'(32'hFFFFE + k - 1);
      chk1($sformatf("wrap_we_k%0d", k), we0, 1'b1);
      chka($sformatf("wrap_addr_k%0d", k), addr0, exp_a);
      chkd($sformatf("wrap_data_k%0d", k), data0, DW'(k));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk1("wrap_done", done0, 1'b1);
    chk1("wrap_we_end", we0, 1'b0);
    chka("wrap_words", words0, 20'd4);

    // Abort after 3 accepts, with an ignored start mid-transfer.
    do_reset();
    drive(1'b1, 20'h00040, 20'd8, 1'b0, 1'b0, '0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) drive(1'b1, 20'h00999, 20'd2, 1'b0, 1'b1, DW'(k));
      else        drive(1'b0, '0, '0, 1'b0, 1'b1, DW'(k));
      tick();
      chk1($sformatf("abt_we_k%0d", k), we0, 1'b1);
      chka($sformatf("abt_addr_k%0d", k), addr0, AW'(32'h40 + k - 1));
      chk1($sformatf("abt_busy_k%0d", k), busy0, 1'b1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1, 18'h3F);
    #2;
    chk1("abt_rdy", rdy0, 1'b0);
    tick();
    chk1("abt_we", we0, 1'b0);
    chk1("abt_busy", busy0, 1'b0);
    chk1("abt_done", done0, 1'b0);
    chka("abt_words", words0, 20'd3);
    chka("abt_addr_hold", addr0, 20'h00042);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 18'h3E);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("abt_nodone_%0d", k), done0, 1'b0);
      chk1($sformatf("abt_nowe_%0d", k), we0, 1'b0);
    end

    // Reset mid-transfer, then a fresh single-word run.
    do_reset();
    drive(1'b1, 20'h00200, 20'd5, 1'b0, 1'b0, '0);
    tick();
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, DW'(32'h70 + k));
      tick();
    end
    chk1("mrst_we_pre", we0, 1'b1);
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 18'h7F);
    tick();
    chk1("mrst_we", we0, 1'b0);
    chka("mrst_addr", addr0, '0);
    chkd("mrst_data", data0, '0);
    chk1("mrst_busy", busy0, 1'b0);
    chk1("mrst_done", done0, 1'b0);
    chka("mrst_words", words0, '0);
    chk1("mrst_rdy", rdy0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 20'h00300, 20'd1, 1'b0, 1'b0, '0);
    tick();
    chk1("post_busy", busy0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 18'h55);
    #2;
    chk1("post_rdy", rdy0, 1'b1);
    tick();
    chk1("post_we", we0, 1'b1);
    chka("post_addr", addr0, 20'h00300);
    chkd("post_data", data0, 18'h55);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk1("post_done", done0, 1'b1);
    chk1("post_busy_end", busy0, 1'b0);
    chka("post_words", words0, 20'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
